// File: rtl/instr_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_sequencer_if
//  Description : Bundle of the instruction-memory read port and the
//                instruction valid/ready channel to the decoder.
//                master = fetch sequencer, slave = memory + decoder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_sequencer_if #(
  parameter int INSTR_WIDTH = 28,
  parameter int IMEM_AWIDTH = 10
) ();

  // Instruction memory read port (synchronous read, data one cycle later)
  logic                   imem_rd_en;
  logic [IMEM_AWIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rd_data;

  // Instruction channel to the decoder
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    output imem_rd_en,
    output imem_addr,
    input  imem_rd_data,
    output instr_out,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_rd_en,
    input  imem_addr,
    output imem_rd_data,
    input  instr_out,
    input  instr_valid,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_sequencer
//  Description : Walks a program in instruction memory from a host-supplied
//                PC, one instruction per FETCH/LOAD/ISSUE round, and hands
//                each word to the decoder over valid/ready. Stops after the
//                END_CHAIN opcode is accepted and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer #(
  parameter int INSTR_WIDTH  = 28,
  parameter int OPCODE_WIDTH = 4,
  parameter int IMEM_AWIDTH  = 10,
  parameter int END_OPCODE   = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_i,
  input  logic [IMEM_AWIDTH-1:0] start_pc_i,
  input  logic                   abort_i,
  instr_fetch_sequencer_if.master bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pc_wrap_o,
  output logic [IMEM_AWIDTH-1:0] pc_out_o
);

  localparam logic [OPCODE_WIDTH-1:0] c_END_OP = OPCODE_WIDTH'(END_OPCODE);
  localparam logic [IMEM_AWIDTH-1:0]  c_PC_ONE = IMEM_AWIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [IMEM_AWIDTH-1:0] pc_q;
  logic [IMEM_AWIDTH-1:0] pc_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   instr_valid_q;
  logic                   imem_rd_en_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pc_wrap_q;
  logic                   is_end_d;
  logic                   pc_last_d;

  // Sequential address wraps naturally at 2^IMEM_AWIDTH.
  assign pc_d      = pc_q + c_PC_ONE;
  assign is_end_d  = (instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] == c_END_OP);
  assign pc_last_d = &pc_q;

  // Sequencer FSM: all outputs are registered so the decoder and memory
  // see glitch-free strobes; abort from any busy state drops to IDLE while
  // keeping pc/instr_out/pc_wrap for host inspection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_rd_en_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_wrap_q     <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      imem_rd_en_q <= 1'b0;
      done_q       <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            pc_q         <= start_pc_i;
            pc_wrap_q    <= 1'b0;
            imem_rd_en_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (abort_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            instr_q       <= bus.imem_rd_data;
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (abort_i) begin
            // A coincident handshake still counts on the decoder side, but
            // the chain stops here with no done pulse and pc left as-is.
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (is_end_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pc_q         <= pc_d;
              imem_rd_en_q <= 1'b1;
              if (pc_last_d) begin
                pc_wrap_q <= 1'b1;
              end
              state_q <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          instr_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_rd_en  = imem_rd_en_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = instr_valid_q;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pc_wrap_o = pc_wrap_q;
  assign pc_out_o  = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_sequencer
//  Description : Scoreboard bench for instr_fetch_sequencer. A program model
//                walks instruction memory to predict the handshake stream;
//                a negedge monitor pops and compares on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_sequencer;

  localparam int IW = 28;
  localparam int AW = 10;
  localparam int END_OP = 12;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          abort;
  logic          busy;
  logic          done;
  logic          pc_wrap;
  logic [AW-1:0] pc_out;

  always #5 clk = ~clk;

  instr_fetch_sequencer_if #(.INSTR_WIDTH(IW), .IMEM_AWIDTH(AW)) bus ();

  instr_fetch_sequencer #(
    .INSTR_WIDTH(IW), .OPCODE_WIDTH(4), .IMEM_AWIDTH(AW), .END_OPCODE(END_OP)
  ) dut (
    .clk(clk), .resetn(resetn), .start_i(start), .start_pc_i(start_pc),
    .abort_i(abort), .bus(bus), .busy_o(busy), .done_o(done),
    .pc_wrap_o(pc_wrap), .pc_out_o(pc_out)
  );

  // Synchronous-read instruction memory
  logic [IW-1:0] imem [0:1023];
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_rd_data <= imem[bus.imem_addr];

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } txn_t;

  txn_t exp_q[$];
  int   exp_done;
  int   tests;
  int   fails;
  bit   rand_ready;
  txn_t mt;
  bit   w;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: follow the program from spc until an END opcode,
  // predicting each accepted (pc, instr) and whether the PC wraps.
  task automatic expect_chain(input logic [AW-1:0] spc, output bit wrap);
    int   p;
    txn_t t;
    p    = int'(spc);
    wrap = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      t.pc    = AW'(p);
      t.instr = imem[p];
      exp_q.push_back(t);
      if (int'(imem[p][IW-1 -: 4]) == END_OP) break;
      if (p == 1023) wrap = 1'b1;
      p = (p + 1) % 1024;
    end
    exp_done++;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.imem_rd_en && exp_q.size() > 0)
        check("fetch_addr", bus.imem_addr, exp_q[0].pc);
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          mt = exp_q.pop_front();
          check("hs_instr", bus.instr_out, mt.instr);
          check("hs_pc", pc_out, mt.pc);
        end
      end
      if (done) begin
        check("done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // Random backpressure driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.instr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_start(input logic [AW-1:0] pc);
    @(posedge clk); #1;
    start    = 1'b1;
    start_pc = pc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check({nm, "_done_seen"}, n < 300, 1);
    @(posedge clk); #1;
    check({nm, "_idle_after_done"}, {busy, done}, 2'b00);
    check({nm, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int            spc;
    int            len;
    int            a;
    logic [3:0]    op;
    logic [IW-1:0] rnd;

    tests = 0; fails = 0; exp_done = 0; rand_ready = 1'b0;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    bus.imem_rd_data = '0;
    bus.instr_ready  = 1'b0;
    start = 1'b0; start_pc = '0; abort = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_valid", bus.instr_valid, 0);
    check("reset_rd_en", bus.imem_rd_en, 0);
    check("reset_done_wrap", {done, pc_wrap}, 2'b00);
    check("reset_pc", pc_out, 0);
    check("reset_addr", bus.imem_addr, 0);
    check("reset_instr", bus.instr_out, 0);
    resetn = 1'b1;

    // Basic run with latency checks
    imem[5] = 28'h4012345;
    imem[6] = 28'hC000000;
    bus.instr_ready = 1'b1;
    expect_chain(10'd5, w);
    do_start(10'd5);
    check("basic_fetch_rd_en", bus.imem_rd_en, 1);
    check("basic_fetch_addr", bus.imem_addr, 5);
    check("basic_busy", busy, 1);
    @(posedge clk); #1;
    check("basic_load_no_valid", {bus.instr_valid, bus.imem_rd_en}, 2'b00);
    @(posedge clk); #1;
    check("basic_issue_valid", bus.instr_valid, 1);
    check("basic_issue_instr", bus.instr_out, 28'h4012345);
    check("basic_issue_pc", pc_out, 5);
    wait_done("basic");
    check("basic_no_wrap", pc_wrap, 0);

    // Backpressure during the first ISSUE
    bus.instr_ready = 1'b0;
    expect_chain(10'd5, w);
    do_start(10'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      check("bp_valid_held", bus.instr_valid, 1);
      check("bp_instr_held", bus.instr_out, 28'h4012345);
      check("bp_no_fetch", bus.imem_rd_en, 0);
      check("bp_pc_held", pc_out, 5);
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_refetch_rd_en", bus.imem_rd_en, 1);
    check("bp_refetch_addr", bus.imem_addr, 6);
    check("bp_valid_dropped", bus.instr_valid, 0);
    wait_done("bp");

    // PC wrap-around
    imem[1023] = 28'h5000000;
    imem[0]    = 28'hC000000;
    expect_chain(10'd1023, w);
    do_start(10'd1023);
    wait_done("wrap");
    check("wrap_flag", pc_wrap, w);
    check("wrap_pc", pc_out, 0);
    expect_chain(10'd5, w);
    do_start(10'd5);
    check("wrap_cleared_by_start", pc_wrap, 0);
    wait_done("after_wrap");

    // Abort during LOAD of a 4-instruction chain
    imem[10] = 28'h1000001;
    imem[11] = 28'h2000002;
    imem[12] = 28'h3000003;
    imem[13] = 28'hC000013;
    expect_chain(10'd10, w);
    do_start(10'd10);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", bus.instr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_en", bus.imem_rd_en, 0);
    check("abort_pc_kept", pc_out, 10);
    exp_q.delete();
    exp_done = 0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_stays_idle", busy, 0);
    expect_chain(10'd0, w);
    do_start(10'd0);
    wait_done("post_abort");

    // Start while busy is ignored
    bus.instr_ready = 1'b0;
    expect_chain(10'd5, w);
    do_start(10'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start    = 1'b1;
    start_pc = 10'd100;
    @(posedge clk); #1;
    start    = 1'b0;
    check("busy_start_pc", pc_out, 5);
    check("busy_start_no_fetch", bus.imem_rd_en, 0);
    check("busy_start_valid", bus.instr_valid, 1);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    check("busy_start_next_addr", bus.imem_addr, 6);
    wait_done("busy_start");

    // Asynchronous reset mid-ISSUE
    bus.instr_ready = 1'b0;
    expect_chain(10'd5, w);
    do_start(10'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    resetn = 1'b0;
    #1;
    check("areset_valid", bus.instr_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_rd_en", bus.imem_rd_en, 0);
    check("areset_pc", pc_out, 0);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("areset_waits_idle", {busy, bus.imem_rd_en, bus.instr_valid}, 3'b000);

    // Randomized chains with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      if (r % 5 == 0) spc = 1023 - $urandom_range(0, 3);
      else            spc = $urandom_range(0, 1023);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        a   = (spc + k) % 1024;
        rnd = IW'($urandom);
        op  = 4'($urandom_range(0, 15));
        if (k == len - 1)            op = 4'(END_OP);
        else if (int'(op) == END_OP) op = 4'd3;
        imem[a] = {op, rnd[IW-5:0]};
      end
      expect_chain(AW'(spc), w);
      do_start(AW'(spc));
      wait_done("rand");
      check("rand_wrap", pc_wrap, w);
    end
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Upstream stage of the instruction decoder.
- Walks a program in on-chip instruction memory starting from a host-supplied PC. Fetches one 28-bit instruction at a time and presents it to the decoder over a valid/ready handshake.
- Halts after the END_CHAIN instruction has been accepted, then pulses done back to the host.

Parameters:
- INSTR_WIDTH, 28, instruction word width (4 opcode + 2 target + 10 + 2 + 10).
- OPCODE_WIDTH, 4, opcode field width; field is instr[INSTR_WIDTH-1 -: OPCODE_WIDTH].
- IMEM_AWIDTH, 10, instruction memory address width.
- END_OPCODE, 12, opcode value that terminates a chain (END_CHAIN).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to run a chain; sampled only in IDLE.
- start_pc  in  IMEM_AWIDTH  first instruction address, captured with start.
- abort  in  1  synchronous cancel; valid in any state.
- imem_rd_en  out  1  instruction memory read strobe.
- imem_addr  out  IMEM_AWIDTH  instruction memory read address.
- imem_rd_data  in  INSTR_WIDTH  read data, valid the cycle after imem_rd_en.
- instr_out  out  INSTR_WIDTH  registered instruction to the decoder.
- instr_valid  out  1  instr_out holds a valid instruction.
- instr_ready  in  1  decoder accepts instr_out this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after END_CHAIN is accepted.
- pc_wrap  out  1  sticky flag: PC wrapped past 2^IMEM_AWIDTH-1; cleared by the next accepted start.
- pc_out  out  IMEM_AWIDTH  address of the instruction currently held or being fetched.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - pc, instr_out = 0.
  - imem_rd_en, instr_valid, done, pc_wrap = 0.
  - busy=0.
  - imem_addr = pc = 0.
- imem_addr always equals pc (combinational from the pc register).
- State machine:
  - IDLE: when start=1 and abort=0: pc<=start_pc, pc_wrap<=0, go FETCH.
  - FETCH: imem_rd_en=1 for exactly this cycle; go LOAD.
  - LOAD: instr_out<=imem_rd_data; go ISSUE.
  - ISSUE: instr_valid=1. instr_out and pc are held stable while instr_ready=0.
    - On instr_valid&instr_ready, if opcode==END_OPCODE: go DONE, pc unchanged.
    - Otherwise: pc<=pc+1 modulo 2^IMEM_AWIDTH. If pc was all-ones, set pc_wrap. Go FETCH.
  - DONE: done=1 for one cycle; go IDLE.
- Latency:
  - start sampled at edge t → imem_rd_en high in cycle t+1 → instr_valid high from cycle t+3.
  - Handshake at edge h → next instr_valid at h+3.
  - Peak throughput: one instruction per 3 cycles.
- instr_valid is registered. It is deasserted on the edge that completes the handshake and never glitches.
- start while busy=1: ignored; no effect on pc or state.
- start and abort in the same IDLE cycle: abort wins; stays IDLE.
- abort=1 in any non-IDLE state:
  - Next state IDLE.
  - instr_valid=0, imem_rd_en=0, done not pulsed.
  - pc and instr_out retain their values; pc_wrap retains its value.
- abort in the same cycle as an ISSUE handshake: the handshake counts (decoder consumed it), but the FSM goes to IDLE and no done pulse is generated.
- Wrap-around is not an error stop. Fetching continues at address 0; the host decides what to do with pc_wrap.
- Reset asserted mid-chain: all outputs return to reset values immediately (asynchronously); no done pulse.
- busy is 1 in FETCH, LOAD, ISSUE and DONE.

Test Plan:
- Basic run: imem[5]=28'h4012345 (MV_MUL), imem[6]=28'hC000000; start with start_pc=5, instr_ready=1.
  - First instr_valid 3 cycles after start, instr_out=28'h4012345, pc_out=5.
  - Then instr_out=28'hC000000, pc_out=6.
  - done pulses one cycle after END_CHAIN is accepted; busy then 0.
- Backpressure: same program, instr_ready=0 for 7 cycles during the first ISSUE.
  - instr_valid stays 1 and instr_out stays 28'h4012345 throughout.
  - imem_rd_en stays 0 and pc_out stays 5.
  - Released ready → next fetch at addr 6 exactly one cycle later.
- Wrap: start_pc=1023, imem[1023]=28'h5000000, imem[0]=28'hC000000.
  - pc_out goes 1023→0 and pc_wrap=1 after the first handshake.
  - Chain ends normally; a subsequent start clears pc_wrap.
- Abort: assert abort during LOAD of a 4-instruction chain.
  - Next cycle state IDLE, instr_valid=0, busy=0, done never pulses.
  - A new start with start_pc=0 runs normally.
- Start while busy: pulse start with start_pc=100 during ISSUE of a chain at pc=5.
  - Ignored: pc continues 5→6 and no fetch occurs at 100.
- Async reset: drop resetn mid-ISSUE, between clock edges.
  - instr_valid, busy, imem_rd_en go 0 without waiting for clk.
  - After release, the FSM waits in IDLE for start.
